xswitch_rr_sched: RTL

//  Round-robin scheduler for the 4x4 xswitch crossbar: one arbiter per output port.

---
 rtl/xswitch_rr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/xswitch_rr_sched.sv
// rtl/xswitch_rr_sched.sv - per-output round-robin arbiters for the 4x4 xswitch crossbar
// Each output runs IDLE -> LOAD -> FULL and owns its rr pointer, mux select and stall timer.
module xswitch_rr_sched #(
  parameter int NPORTS   = 4,
  parameter int PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  parameter int STALL_TO = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    valid_in,
  input  logic [NPORTS*PW-1:0] dest_in,
  output logic [NPORTS-1:0]    rcv_rdy,
  output logic [NPORTS*PW-1:0] sel_out,
  output logic [NPORTS-1:0]    load_out,
  output logic [NPORTS-1:0]    valid_out,
  input  logic [NPORTS-1:0]    data_rd,
  output logic [NPORTS-1:0]    stall_err
);

  localparam int CW = (STALL_TO > 0) ? $clog2(STALL_TO + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_e;

  state_e            state_q [NPORTS];
  state_e            state_d [NPORTS];
  logic [PW-1:0]     ptr_q   [NPORTS];
  logic [PW-1:0]     ptr_d   [NPORTS];
  logic [PW-1:0]     sel_q   [NPORTS];
  logic [PW-1:0]     sel_d   [NPORTS];
  logic [CW-1:0]     cnt_q   [NPORTS];
  logic [CW-1:0]     cnt_d   [NPORTS];
  logic [PW-1:0]     dest_a  [NPORTS];
  logic [NPORTS-1:0] rcv_q, rcv_d;
  logic [NPORTS-1:0] load_q, load_d;
  logic [NPORTS-1:0] full_q, full_d;
  logic [NPORTS-1:0] err_q, err_d;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      dest_a[i] = dest_in[i*PW +: PW];
    end
  end

  always_comb begin
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    rcv_d  = '0;
    load_d = '0;
    full_d = '0;
    err_d  = err_q;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      sel_d[o]   = sel_q[o];
      cnt_d[o]   = cnt_q[o];
      found      = 1'b0;
      win        = '0;
      // Search starts at the pointer and wraps, so the last winner becomes lowest priority.
      for (int k = 0; k < NPORTS; k++) begin
        idx = PW'((int'(ptr_q[o]) + k) % NPORTS);
        if (!found && valid_in[idx] && dest_a[idx] == PW'(o)) begin
          found = 1'b1;
          win   = idx;
        end
      end
      unique case (state_q[o])
        S_IDLE: begin
          if (found) begin
            state_d[o] = S_LOAD;
            sel_d[o]   = win;
            ptr_d[o]   = (win == PW'(NPORTS - 1)) ? '0 : win + 1'b1;
            load_d[o]  = 1'b1;
            rcv_d[win] = 1'b1;
          end
        end
        S_LOAD: begin
          state_d[o] = S_FULL;
          cnt_d[o]   = '0;
          full_d[o]  = 1'b1;
        end
        S_FULL: begin
          if (data_rd[o]) begin
            state_d[o] = S_IDLE;
          end else begin
            full_d[o] = 1'b1;
            // cnt_q counts completed FULL cycles; the flag rises as it reaches the limit.
            if (STALL_TO > 0) begin
              if (cnt_q[o] != CW'(STALL_TO)) cnt_d[o] = cnt_q[o] + 1'b1;
              if (cnt_q[o] >= CW'(STALL_TO - 1)) err_d[o] = 1'b1;
            end
          end
        end
        default: state_d[o] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= S_IDLE;
        ptr_q[o]   <= '0;
        sel_q[o]   <= '0;
        cnt_q[o]   <= '0;
      end
      rcv_q  <= '0;
      load_q <= '0;
      full_q <= '0;
      err_q  <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        sel_q[o]   <= sel_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      rcv_q  <= rcv_d;
      load_q <= load_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    sel_out = '0;
    for (int o = 0; o < NPORTS; o++) begin
      sel_out[o*PW +: PW] = sel_q[o];
    end
  end

  assign rcv_rdy   = rcv_q;
  assign load_out  = load_q;
  assign valid_out = full_q;
  assign stall_err = err_q;

endmodule
